// File: rtl/ysyx_25020081_ifu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_25020081_ifu                                                          |
// | Instruction fetch unit: owns the fetch PC, reads words from instruction    |
// | memory and presents them to the core through a valid/ready handshake.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ysyx_25020081_ifu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h80000000
) (
    input  logic                  clk,
    input  logic                  rst,

    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,

    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  inst_fault,

    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h00000013);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   fetch_pc;
    logic                    drop;
    logic [ADDR_WIDTH-1:0]   tgt;

    // A "landing" moves fetch to a new target: either a drop completing or a
    // redirect taken in HOLD. A redirect that coincides with a response in WAIT
    // discards that response and lands directly on the newest target.
    logic                    land;
    logic [ADDR_WIDTH-1:0]   land_pc;
    logic                    land_misaligned;

    always_comb begin
        land    = 1'b0;
        land_pc = tgt;
        case (state)
            WAIT: begin
                if (imem_rsp_valid && redirect_valid) begin
                    land    = 1'b1;
                    land_pc = redirect_pc;
                end else if (imem_rsp_valid && drop) begin
                    land    = 1'b1;
                    land_pc = tgt;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    land    = 1'b1;
                    land_pc = redirect_pc;
                end
            end
            default: begin
                land    = 1'b0;
                land_pc = tgt;
            end
        endcase
    end

    assign land_misaligned = (land_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= REQ;
            fetch_pc   <= RESET_PC;
            drop       <= 1'b0;
            tgt        <= '0;
            inst       <= '0;
            pc         <= RESET_PC;
            inst_fault <= 1'b0;
        end else if (land) begin
            drop     <= 1'b0;
            fetch_pc <= land_pc;
            if (land_misaligned) begin
                // Misaligned targets never reach memory; a fault marker is shown instead.
                state      <= HOLD;
                inst       <= NOP_INST;
                pc         <= land_pc;
                inst_fault <= 1'b1;
            end else begin
                state <= REQ;
            end
        end else begin
            case (state)
                REQ: begin
                    // The request stays as issued; a redirect only arms the drop.
                    if (redirect_valid) begin
                        drop <= 1'b1;
                        tgt  <= redirect_pc;
                    end
                    if (imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        drop <= 1'b1;
                        tgt  <= redirect_pc;
                    end else if (imem_rsp_valid) begin
                        state      <= HOLD;
                        inst       <= imem_rsp_data;
                        pc         <= fetch_pc;
                        inst_fault <= imem_rsp_err;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        state    <= REQ;
                        fetch_pc <= pc + PC_STEP;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

    assign imem_req_valid = rst && (state == REQ);
    assign imem_req_addr  = fetch_pc;
    assign inst_valid     = rst && (state == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020081_ifu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ysyx_25020081_ifu                                                       |
// | Scoreboard bench for the fetch unit with a small instruction memory model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ysyx_25020081_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ysyx_25020081_ifu #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h80000000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i;
        logic [31:0] p;
        logic        f;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t        exp_inst_q[$];
    logic [31:0] exp_req_q[$];
    pend_t       pend_q[$];

    int          assertions = 0;
    int          failures   = 0;
    int          rsp_lat    = 1;
    logic [31:0] err_addr   = 32'hFFFFFFFF;
    logic [31:0] rsp_addr   = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[11:0], 20'h00093};
    endfunction

    function automatic exp_t mk(input logic [31:0] i, input logic [31:0] p, input logic f);
        exp_t e;
        e.i = i;
        e.p = p;
        e.f = f;
        return e;
    endfunction

    // Memory model: fixed latency per request, in order, not reset with the DUT
    // so that a response to an abandoned request can arrive late.
    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        int          mcyc;
        pend_t       pe;
        mcyc           = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            acc      = rst && imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            @(posedge clk);
            #1;
            mcyc++;
            if (acc) begin
                pe.addr = acc_addr;
                pe.due  = mcyc - 1 + rsp_lat;
                pend_q.push_back(pe);
            end
            if (pend_q.size() > 0 && pend_q[0].due <= mcyc) begin
                pe             = pend_q.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pe.addr);
                imem_rsp_err   = (pe.addr == err_addr);
                rsp_addr       = pe.addr;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
                imem_rsp_err   = 1'b0;
            end
        end
    end

    // Monitor: request addresses and consumed instructions against the queues.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (imem_req_valid) begin
                    if (exp_req_q.size() == 0) begin
                        check("unexpected_req", imem_req_addr, 32'hXXXXXXXX);
                    end else begin
                        check("req_addr", imem_req_addr, exp_req_q[0]);
                        if (imem_req_ready) void'(exp_req_q.pop_front());
                    end
                end
                if (inst_valid && inst_ready) begin
                    if (exp_inst_q.size() == 0) begin
                        check("unexpected_inst_pc", pc, 32'hXXXXXXXX);
                    end else begin
                        e = exp_inst_q.pop_front();
                        check("inst", inst, e.i);
                        check("inst_pc", pc, e.p);
                        check("inst_fault", {31'b0, inst_fault}, {31'b0, e.f});
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_inst_empty(input string name);
        int n = 0;
        while (exp_inst_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        if (exp_inst_q.size() != 0) check({name, "_timeout"}, exp_inst_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid}, 0);
        check("rst_inst_valid", {31'b0, inst_valid}, 0);
        check("rst_pc", pc, 32'h80000000);
        check("rst_inst", inst, 32'h0);
        check("rst_fault", {31'b0, inst_fault}, 0);

        // First fetch, then a 5-cycle hold with inst_ready low
        exp_req_q.push_back(32'h80000000);
        exp_inst_q.push_back(mk(32'h00000093, 32'h80000000, 1'b0));
        exp_req_q.push_back(32'h80000004);
        exp_inst_q.push_back(mk(32'h00400093, 32'h80000004, 1'b0));
        exp_req_q.push_back(32'h80000008);
        exp_inst_q.push_back(mk(32'h00800093, 32'h80000008, 1'b1));
        exp_req_q.push_back(32'h8000000C);
        err_addr = 32'h80000008;
        step();
        rst = 1'b1;
        @(negedge clk);
        check("c1_req_valid", {31'b0, imem_req_valid}, 1);
        @(negedge clk);
        check("c2_inst_valid", {31'b0, inst_valid}, 0);
        @(negedge clk);
        check("c3_inst_valid", {31'b0, inst_valid}, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_inst", inst, 32'h00000093);
            check("hold_pc", pc, 32'h80000000);
            check("hold_req_valid", {31'b0, imem_req_valid}, 0);
        end
        step();
        inst_ready = 1'b1;
        wait_inst_empty("seq_fetch");

        // Request stalled 4 cycles with a redirect in cycle 2
        imem_req_ready = 1'b0;
        exp_req_q.push_back(32'h80000100);
        exp_inst_q.push_back(mk(32'h10000093, 32'h80000100, 1'b0));
        exp_req_q.push_back(32'h80000104);
        exp_req_q.push_back(32'h80000200);
        exp_inst_q.push_back(mk(32'h20000093, 32'h80000200, 1'b0));
        exp_req_q.push_back(32'h80000204);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80000100;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        imem_req_ready = 1'b1;

        // Redirect coinciding with the response to 0x80000104
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_rsp_valid && rsp_addr == 32'h80000104) && n < 50);
        if (n >= 50) check("rsp_104_timeout", n, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80000200;
        step();
        redirect_valid = 1'b0;
        wait_inst_empty("redirect_wait");

        // Misaligned redirect in HOLD
        inst_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_valid && n < 50);
        if (n >= 50) check("hold_204_timeout", n, 0);
        check("hold_204_pc", pc, 32'h80000204);
        exp_inst_q.push_back(mk(32'h00000013, 32'h80000102, 1'b1));
        exp_req_q.push_back(32'h80000106);
        exp_inst_q.push_back(mk(32'h10600093, 32'h80000106, 1'b0));
        exp_req_q.push_back(32'h8000010A);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80000102;
        step();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        @(negedge clk);
        check("mis_inst_valid", {31'b0, inst_valid}, 1);
        check("mis_no_req", {31'b0, imem_req_valid}, 0);
        wait_inst_empty("misaligned");

        // Reset while waiting on 0x8000010A; its response arrives after release
        rsp_lat = 2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req_valid && imem_req_ready && imem_req_addr == 32'h8000010A) && n < 50);
        if (n >= 50) check("req_10a_timeout", n, 0);
        step();
        rst = 1'b0;
        exp_req_q.push_back(32'h80000000);
        exp_inst_q.push_back(mk(32'h00000093, 32'h80000000, 1'b0));
        exp_req_q.push_back(32'h80000004);
        @(negedge clk);
        check("mid_rst_req_valid", {31'b0, imem_req_valid}, 0);
        check("mid_rst_inst_valid", {31'b0, inst_valid}, 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_pc", pc, 32'h80000000);
        check("post_rst_inst", inst, 32'h0);
        wait_inst_empty("post_reset");
        imem_req_ready = 1'b0;
        repeat (4) step();
        check("final_inst_q", exp_inst_q.size(), 0);
        check("final_req_q", exp_req_q.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
`default_nettype wire
